// File: rtl/fetch_unit.sv
// Instruction fetch unit: 2-way set-associative icache with a single
// outstanding line fill, next-pc selection from the branch predictor and
// a small in-order instruction queue towards decode.
// SETS must be at least 2 so the index field is non-empty.

module fetch_unit #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SETS       = 16,
    parameter int unsigned IQ_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    output logic                       mem_req_valid,
    output logic [31:0]                mem_req_addr,
    input  logic                       mem_resp_valid,
    input  logic [32*LINE_WORDS-1:0]   mem_resp_data,
    output logic [31:0]                pdt_pc,
    output logic [31:0]                pdt_inst,
    input  logic                       pdt_taken,
    input  logic [31:0]                pdt_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic                       out_pred_taken,
    output logic [31:0]                out_fallthrough_pc
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;
    localparam int unsigned QP_W  = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(IQ_DEPTH + 1);

    typedef enum logic [0:0] {
        StRun,
        StMissWait
    } state_e;

    // Fetch state
    state_e      state;
    logic [31:0] pc;
    logic        req_pulse;
    logic [31:0] miss_addr;

    // Cache storage; lru[s] names the way to evict next in set s
    logic [SETS-1:0]  valid0, valid1, lru;
    logic [TAG_W-1:0] tag0 [SETS];
    logic [TAG_W-1:0] tag1 [SETS];
    logic [31:0]      data0 [SETS][LINE_WORDS];
    logic [31:0]      data1 [SETS][LINE_WORDS];

    // Instruction queue storage
    logic [31:0]      q_pc   [IQ_DEPTH];
    logic [31:0]      q_inst [IQ_DEPTH];
    logic             q_taken[IQ_DEPTH];
    logic [31:0]      q_fall [IQ_DEPTH];
    logic [QP_W-1:0]  q_head, q_tail;
    logic [CNT_W-1:0] q_count;

    // Lookup fields of the current pc
    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             hit0, hit1, hit;
    logic [31:0]      hit_inst;

    // Fill fields come from the latched miss address, not the live pc,
    // so a flush during the fill cannot redirect where the line lands.
    logic [IDX_W-1:0] fill_index;
    logic [TAG_W-1:0] fill_tag;
    logic             fill_way1;

    logic q_full;
    logic do_push, do_pop, do_fill;

    function automatic logic [QP_W-1:0] ptr_inc(input logic [QP_W-1:0] p);
        return (p == QP_W'(IQ_DEPTH - 1)) ? '0 : p + QP_W'(1);
    endfunction

    // Combinational tag compare and word select on the current pc
    always_comb begin
        offset   = pc[OFF_W+1:2];
        index    = pc[OFF_W+2 +: IDX_W];
        tag      = pc[31 -: TAG_W];
        hit0     = valid0[index] && (tag0[index] == tag);
        hit1     = valid1[index] && (tag1[index] == tag);
        hit      = hit0 || hit1;
        hit_inst = '0;
        if (hit0) begin
            hit_inst = data0[index][offset];
        end else if (hit1) begin
            hit_inst = data1[index][offset];
        end
    end

    // Victim choice: first invalid way, otherwise the LRU way
    always_comb begin
        fill_index = miss_addr[OFF_W+2 +: IDX_W];
        fill_tag   = miss_addr[31 -: TAG_W];
        if (!valid0[fill_index]) begin
            fill_way1 = 1'b0;
        end else if (!valid1[fill_index]) begin
            fill_way1 = 1'b1;
        end else begin
            fill_way1 = lru[fill_index];
        end
    end

    // Per-cycle actions; a flush cancels push and pop but never a fill
    always_comb begin
        q_full  = (q_count == CNT_W'(IQ_DEPTH));
        out_valid = (q_count != '0);
        do_fill = rdy && (state == StMissWait) && mem_resp_valid;
        do_push = rdy && !flush && (state == StRun) && hit && !q_full;
        do_pop  = rdy && !flush && out_valid && out_ready;
    end

    // Fetch FSM: pc update, miss request pulse and fill completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StRun;
            pc        <= '0;
            req_pulse <= 1'b0;
            miss_addr <= '0;
        end else if (rdy) begin
            req_pulse <= 1'b0;
            case (state)
                StRun: begin
                    if (flush) begin
                        pc <= flush_pc;
                    end else if (hit) begin
                        if (!q_full) begin
                            pc <= pdt_taken ? pdt_target : pc + 32'd4;
                        end
                    end else begin
                        req_pulse <= 1'b1;
                        miss_addr <= {pc[31:OFF_W+2], {(OFF_W + 2){1'b0}}};
                        state     <= StMissWait;
                    end
                end
                StMissWait: begin
                    if (mem_resp_valid) begin
                        state <= StRun;
                    end
                    if (flush) begin
                        pc <= flush_pc;
                    end
                end
                default: state <= StRun;
            endcase
        end
    end

    // Valid and LRU bits: set on fill, LRU points away from the touched way
    always_ff @(posedge clk) begin
        if (rst) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else if (do_fill) begin
            if (fill_way1) begin
                valid1[fill_index] <= 1'b1;
                lru[fill_index]    <= 1'b0;
            end else begin
                valid0[fill_index] <= 1'b1;
                lru[fill_index]    <= 1'b1;
            end
        end else if (do_push) begin
            lru[index] <= hit0;
        end
    end

    // Tag and line storage written by the fill; no reset needed
    always_ff @(posedge clk) begin
        if (!rst && do_fill) begin
            if (fill_way1) begin
                tag1[fill_index] <= fill_tag;
                for (int w = 0; w < LINE_WORDS; w++) begin
                    data1[fill_index][w] <= mem_resp_data[w*32 +: 32];
                end
            end else begin
                tag0[fill_index] <= fill_tag;
                for (int w = 0; w < LINE_WORDS; w++) begin
                    data0[fill_index][w] <= mem_resp_data[w*32 +: 32];
                end
            end
        end
    end

    // Queue pointers and occupancy; flush empties the queue outright
    always_ff @(posedge clk) begin
        if (rst) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else if (rdy) begin
            if (flush) begin
                q_head  <= '0;
                q_tail  <= '0;
                q_count <= '0;
            end else begin
                if (do_push) begin
                    q_tail <= ptr_inc(q_tail);
                end
                if (do_pop) begin
                    q_head <= ptr_inc(q_head);
                end
                q_count <= q_count + CNT_W'(do_push) - CNT_W'(do_pop);
            end
        end
    end

    // Queue entry payload
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            q_pc[q_tail]    <= pc;
            q_inst[q_tail]  <= hit_inst;
            q_taken[q_tail] <= pdt_taken;
            q_fall[q_tail]  <= pc + 32'd4;
        end
    end

    // Outputs; the queue head reads as zero while empty
    always_comb begin
        mem_req_valid      = req_pulse && rdy;
        mem_req_addr       = miss_addr;
        pdt_pc             = pc;
        pdt_inst           = hit_inst;
        out_pc             = out_valid ? q_pc[q_head] : '0;
        out_inst           = out_valid ? q_inst[q_head] : '0;
        out_pred_taken     = out_valid ? q_taken[q_head] : 1'b0;
        out_fallthrough_pc = out_valid ? q_fall[q_head] : '0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model: the
// cache is a per-set recency list of line addresses, the queue is an SV
// queue and memory contents are a fixed hash of the word address.

module tb_fetch_unit;

    localparam int unsigned LW = 4;
    localparam int unsigned NS = 16;
    localparam int unsigned QD = 4;
    localparam int unsigned LB = LW * 4;
    localparam int unsigned NPH = 5;

    logic             clk = 1'b0;
    logic             rst, rdy, flush;
    logic [31:0]      flush_pc;
    logic             mem_req_valid;
    logic [31:0]      mem_req_addr;
    logic             mem_resp_valid;
    logic [32*LW-1:0] mem_resp_data;
    logic [31:0]      pdt_pc, pdt_inst;
    logic             pdt_taken;
    logic [31:0]      pdt_target;
    logic             out_valid, out_ready;
    logic [31:0]      out_pc, out_inst;
    logic             out_pred_taken;
    logic [31:0]      out_fallthrough_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .LINE_WORDS(LW),
        .SETS      (NS),
        .IQ_DEPTH  (QD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .mem_req_valid     (mem_req_valid),
        .mem_req_addr      (mem_req_addr),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .pdt_pc            (pdt_pc),
        .pdt_inst          (pdt_inst),
        .pdt_taken         (pdt_taken),
        .pdt_target        (pdt_target),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_inst          (out_inst),
        .out_pred_taken    (out_pred_taken),
        .out_fallthrough_pc(out_fallthrough_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Backing memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_1234;
    endfunction

    function automatic logic [32*LW-1:0] mem_line(input logic [31:0] la);
        logic [32*LW-1:0] l;
        for (int w = 0; w < LW; w++) l[w*32 +: 32] = mem_word(la + 32'(4 * w));
        return l;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(LB - 1);
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a / LB) % NS);
    endfunction

    // Mostly a small region so lines get reused and sets conflict
    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 32'h7FF)) & ~32'h3;
        if ($urandom_range(0, 99) < 10) a = a | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 99) < 2) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        return a;
    endfunction

    // Reference model state
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] fall;
    } entry_t;

    logic [31:0] m_pc;
    bit          m_wait;
    bit          m_req;
    logic [31:0] m_req_addr;
    entry_t      m_q[$];
    logic [31:0] m_lines[NS][2];  // [0] = most recently used
    int          m_n[NS];

    function automatic int m_find(input logic [31:0] a);
        int s;
        s = set_of(a);
        for (int i = 0; i < m_n[s]; i++) if (m_lines[s][i] == line_of(a)) return i;
        return -1;
    endfunction

    task automatic m_touch(input logic [31:0] a, input int pos);
        int s;
        logic [31:0] t;
        s = set_of(a);
        if (pos == 1) begin
            t = m_lines[s][0];
            m_lines[s][0] = m_lines[s][1];
            m_lines[s][1] = t;
        end
    endtask

    task automatic m_insert(input logic [31:0] la);
        int s;
        s = set_of(la);
        m_lines[s][1] = m_lines[s][0];
        m_lines[s][0] = la;
        if (m_n[s] < 2) m_n[s]++;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic m_step();
        int  pos;
        bit  pop, full;
        entry_t e;
        if (rst) begin
            m_pc = '0; m_wait = 0; m_req = 0; m_req_addr = '0;
            m_q.delete();
            for (int s = 0; s < NS; s++) m_n[s] = 0;
            return;
        end
        if (!rdy) return;
        pos  = m_find(m_pc);
        m_req = 0;
        pop  = (m_q.size() > 0) && out_ready && !flush;
        full = (m_q.size() >= QD);
        if (m_wait) begin
            if (mem_resp_valid) begin
                m_insert(m_req_addr);
                m_wait = 0;
            end
            if (flush) begin
                m_pc = flush_pc;
                m_q.delete();
            end else if (pop) begin
                m_q.delete(0);
            end
        end else if (flush) begin
            m_pc = flush_pc;
            m_q.delete();
        end else begin
            if (pop) m_q.delete(0);
            if (pos >= 0) begin
                if (!full) begin
                    e.pc = m_pc; e.inst = mem_word(m_pc & ~32'h3);
                    e.taken = pdt_taken; e.fall = m_pc + 32'd4;
                    m_q.push_back(e);
                    m_touch(m_pc, pos);
                    m_pc = pdt_taken ? pdt_target : m_pc + 32'd4;
                end
            end else begin
                m_req = 1; m_req_addr = line_of(m_pc); m_wait = 1;
            end
        end
    endtask

    task automatic check_outputs();
        entry_t h;
        h = '0;
        if (m_q.size() > 0) h = m_q[0];
        check_eq("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check_eq("out_pc", out_pc, h.pc);
        check_eq("out_inst", out_inst, h.inst);
        check_eq("out_pred_taken", 32'(out_pred_taken), 32'(h.taken));
        check_eq("out_fallthrough_pc", out_fallthrough_pc, h.fall);
        check_eq("pdt_pc", pdt_pc, m_pc);
        check_eq("pdt_inst", pdt_inst, (m_find(m_pc) >= 0) ? mem_word(m_pc & ~32'h3) : 32'h0);
        check_eq("mem_req_valid", 32'(mem_req_valid), 32'(m_req && rdy));
        check_eq("mem_req_addr", mem_req_addr, m_req_addr);
    endtask

    // Phases: cold start, backpressure, flush-heavy, rdy toggling, resets
    int ph_cyc [NPH] = '{80, 600, 800, 800, 1000};
    int ph_rdy [NPH] = '{100, 100, 100, 60, 85};
    int ph_fl  [NPH] = '{0, 0, 8, 4, 3};
    int ph_rd  [NPH] = '{100, 10, 70, 60, 60};
    int ph_tk  [NPH] = '{0, 10, 15, 15, 15};
    int ph_rst [NPH] = '{0, 0, 0, 0, 5};  // per mille

    // Memory responder state (environment, not model)
    bit          r_busy;
    logic [31:0] r_addr;
    int          r_delay;

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = '0;
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        pdt_taken = 1'b0; pdt_target = '0; out_ready = 1'b0;
        r_busy = 0; r_addr = '0; r_delay = 0;
        repeat (2) @(posedge clk);
        m_step();
        for (int p = 0; p < NPH; p++) begin
            for (int c = 0; c < ph_cyc[p]; c++) begin
                @(negedge clk);
                rst        = ($urandom_range(0, 999) < ph_rst[p]);
                rdy        = ($urandom_range(0, 99) < ph_rdy[p]);
                flush      = ($urandom_range(0, 99) < ph_fl[p]);
                flush_pc   = rand_addr();
                out_ready  = ($urandom_range(0, 99) < ph_rd[p]);
                pdt_taken  = ($urandom_range(0, 99) < ph_tk[p]);
                pdt_target = rand_addr();
                for (int w = 0; w < LW; w++) mem_resp_data[w*32 +: 32] = $urandom;
                mem_resp_valid = 1'b0;
                if (r_busy && r_delay == 0 && rdy && !rst) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_line(r_addr);
                end
                #2;
                check_outputs();
                if (rst) begin
                    r_busy = 0;
                end else if (rdy) begin
                    if (mem_resp_valid) r_busy = 0;
                    else if (r_busy && r_delay > 0) r_delay--;
                    if (mem_req_valid) begin
                        r_busy  = 1;
                        r_addr  = mem_req_addr;
                        r_delay = $urandom_range(0, 4);
                    end
                end
                m_step();
            end
        end
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; mem_resp_valid = 1'b0;
        #2;
        check_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
